// File: rtl/div_unit.sv
// Radix-2 restoring divider (signed/unsigned) with a start/hold handshake,
// flush input and a combinational pipeline stall request.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_W-1:0]     rem_reg, rem_next;
    logic [DATA_W-1:0]     quo_reg, quo_next;
    logic [DATA_W-1:0]     dvsr_reg, dvsr_next;
    logic                  neg_q_reg, neg_q_next;
    logic                  neg_r_reg, neg_r_next;
    logic [2*DATA_W-1:0]   result_reg, result_next;

    logic                  op1_neg, op2_neg;
    logic [DATA_W-1:0]     op1_abs, op2_abs;
    logic [DATA_W:0]       shifted, diff;
    logic [DATA_W-1:0]     quo_fix, rem_fix;

    assign op1_neg = signed_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    // Partial remainder shifted left by one, pulling in the next dividend bit;
    // a clear MSB on the trial difference means no borrow.
    assign shifted = {rem_reg, quo_reg[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvsr_reg};

    assign quo_fix = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_fix = neg_r_reg ? -rem_reg : rem_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= FREE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvsr_reg   <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dvsr_reg   <= dvsr_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dvsr_next   = dvsr_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;

        case (state_reg)
            FREE: begin
                result_next = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = BYZERO;
                    end else begin
                        state_next = ON;
                        cnt_next   = '0;
                        rem_next   = '0;
                        quo_next   = op1_abs;
                        dvsr_next  = op2_abs;
                        neg_q_next = op1_neg ^ op2_neg;
                        neg_r_next = op1_neg;
                    end
                end
            end
            BYZERO: begin
                result_next = '0;
                state_next  = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_next  = FREE;
                    cnt_next    = '0;
                    result_next = '0;
                end else if (cnt_reg != CNT_W'(DATA_W)) begin
                    if (!diff[DATA_W]) begin
                        rem_next = diff[DATA_W-1:0];
                        quo_next = {quo_reg[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_next = shifted[DATA_W-1:0];
                        quo_next = {quo_reg[DATA_W-2:0], 1'b0};
                    end
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    result_next = {rem_fix, quo_fix};
                    state_next  = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_next  = FREE;
                    result_next = '0;
                end
            end
            default: state_next = FREE;
        endcase
    end

    assign result_o   = result_reg;
    assign ready_o    = (state_reg == END);
    // Gated with rst so the pipeline sees no stall while the unit is held in reset.
    assign stallreq_o = rst & start_i & ~annul_i & (state_reg != END);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge
// monitor pops and compares them whenever ready_o rises.
module tb_div_unit;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i, annul_i, signed_i;
    logic [W-1:0]   opdata1_i, opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o, stallreq_o;

    int checks      = 0;
    int failures    = 0;
    int ready_rises = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;
    logic           ready_q = 1'b0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_val);
        end
    endtask

    // Monitor: one scoreboard pop per rising edge of ready_o.
    always @(negedge clk) begin
        if (ready_o && !ready_q) begin
            ready_rises++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got result %h expected no result", result_o);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("div result %h expected %h", result_o, mon_exp);
                check("result", result_o, mon_exp);
            end
        end
        ready_q = ready_o;
    end

    task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_val, input int exp_lat,
                          input int hold, input bit scramble);
        int edges  = 0;
        int stalls = 0;
        exp_q.push_back(exp_val);
        @(posedge clk); #2;
        start_i = 1'b1; annul_i = 1'b0; signed_i = sgn; opdata1_i = a; opdata2_i = b;
        while (edges < 200) begin
            @(negedge clk);
            if (ready_o) break;
            if (stallreq_o) stalls++;
            @(posedge clk);
            edges++;
            if (scramble && edges == 1) begin
                #2;
                opdata1_i = 32'h5A5A_5A5A; opdata2_i = '0; signed_i = ~sgn;
            end
        end
        check("latency", 64'(edges), 64'(exp_lat));
        check("stall_cycles", 64'(stalls), 64'(exp_lat));
        check("stall_in_end", 64'(stallreq_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~signed_i;
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp_val);
        end
        @(posedge clk); #2;
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("free_ready", 64'(ready_o), 64'd0);
        check("free_result", result_o, 64'd0);
    endtask

    initial begin
        int rises_before;
        rst = 1'b0; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        #12;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #2;
        start_i = 1'b0; rst = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 5, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 0, 1'b0);
        do_div(1'b0, 32'h1234, 32'h0, 64'h0, 2, 0, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34, 0, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 34, 0, 1'b0);
        do_div(1'b0, 32'hFFFF_FFF9, 32'h2, {32'd1, 32'h7FFF_FFFC}, 34, 0, 1'b0);
        do_div(1'b0, 32'h8000_0000, 32'd3, {32'd2, 32'h2AAA_AAAA}, 34, 0, 1'b1);

        // Flush in ON cycle 10: no result must ever appear.
        rises_before = ready_rises;
        @(posedge clk); #2;
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2; annul_i = 1'b1;
        @(posedge clk); #2;
        annul_i = 1'b0; start_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o || result_o != '0) break;
        end
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        check("annul_no_rise", 64'(ready_rises), 64'(rises_before));
        $display("annul transaction done");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34, 0, 1'b0);

        // Asynchronous reset between edges in ON cycle 20.
        rises_before = ready_rises;
        @(posedge clk); #2;
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #4; rst = 1'b0;
        #1;
        check("async_rst_ready", 64'(ready_o), 64'd0);
        check("async_rst_result", result_o, 64'd0);
        check("async_rst_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #2;
        start_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        check("async_rst_no_rise", 64'(ready_rises), 64'(rises_before));
        $display("async reset transaction done");
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the sole clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port start_i, input, 1, division request from EX, held high until the result is consumed.
REQ-005 The block SHALL have port annul_i, input, 1, cancel the in-flight division (flush).
REQ-006 The block SHALL have port signed_i, input, 1: 1 = signed (div), 0 = unsigned (divu).
REQ-007 The block SHALL have port opdata1_i, input, DATA_W, the dividend.
REQ-008 The block SHALL have port opdata2_i, input, DATA_W, the divisor.
REQ-009 The block SHALL have port result_o, output, 2*DATA_W: {remainder, quotient}, i.e. upper half to HI, lower half to LO.
REQ-010 The block SHALL have port ready_o, output, 1, result valid.
REQ-011 The block SHALL have port stallreq_o, output, 1, stall request to the pipeline controller.

Function
REQ-012 The block SHALL implement a radix-2 restoring divider with states FREE, BYZERO, ON and END.
REQ-013 FREE: start_i=1 and annul_i=0 with opdata2_i==0 SHALL go to BYZERO; with divisor nonzero it SHALL go to ON.
REQ-014 On the FREE-to-ON transition, the block SHALL latch operands, clear the iteration counter to 0 and load the partial remainder/dividend register.
REQ-015 When signed_i=1, the block SHALL latch absolute values of negative operands (two's complement).
REQ-016 The block SHALL latch the sign of the dividend and the XOR of both operand signs, for the final sign fix.
REQ-017 ON, with counter < DATA_W: each cycle the block SHALL perform one shift/subtract step, set the quotient bit = 1 if the trial subtraction is non-negative (keeping the remainder), and increment the counter.
REQ-018 ON, with counter == DATA_W: the block SHALL apply the sign fix, register the result and go to END.
- ON lasts exactly DATA_W+1 cycles.
REQ-019 Sign fix: the quotient SHALL be negated iff signed_i and the operand signs differ, and the remainder SHALL be negated iff signed_i and the dividend is negative.
- Widths stay DATA_W; overflow wraps.
REQ-020 BYZERO: result_o SHALL be 0, and the block SHALL go to END on the next edge.
REQ-021 END: ready_o SHALL be 1 and result_o SHALL be held stable.
- Stay in END while start_i=1.
- Go to FREE on the first edge with start_i=0; ready_o and result_o return to 0 there.
REQ-022 annul_i=1 in ON or BYZERO SHALL return the block to FREE on the next edge without asserting ready_o; the result register SHALL be cleared.
REQ-023 annul_i=1 in END SHALL return the block to FREE on the next edge.
REQ-024 annul_i SHALL take precedence over start_i in every state.
REQ-025 stallreq_o SHALL be combinational: start_i & ~annul_i & (state != END).
- Consequence: the pipeline stalls from the request cycle until the first END cycle.
REQ-026 Latency SHALL be:
- nonzero divisor: ready_o high after DATA_W+2 rising edges following the edge sampling start_i (34 for DATA_W=32);
- zero divisor: ready_o high after 2 edges.
REQ-027 Operand changes on opdata1_i, opdata2_i or signed_i after the FREE-to-ON transition SHALL NOT affect the result.

Reset
REQ-028 rst=0 SHALL immediately force state=FREE, counter=0, result_o=0, ready_o=0 and clear all internal registers, independent of clk.
REQ-029 stallreq_o SHALL be 0 while rst=0.
REQ-030 Reset deassertion SHALL be synchronised externally; the first valid request is the first rising edge with rst=1.

Verification
REQ-031 Unsigned 100/7, start held: stallreq_o high for 34 cycles, then ready_o=1 and result_o={32'd2, 32'd14}; start_i low -> FREE next edge.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x2): result_o={32'hFFFFFFFF, 32'hFFFFFFFD}.
- Also check signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-033 Divisor 0, dividend 0x1234: ready_o after 2 edges with result_o=0; stallreq_o drops in the END cycle.
REQ-034 Unsigned 0xFFFFFFFF/1, annul_i pulsed in ON cycle 10: FREE next edge, ready_o never asserted, result_o=0.
- Then rerun without the annul: result_o={32'd0, 32'hFFFFFFFF}.
REQ-035 rst driven low mid-ON (cycle 20), asynchronously between edges: all outputs 0 immediately.
- After release, a new 9/3 request yields {0, 3} in 34 cycles.
REQ-036 Hold start_i high for 5 cycles in END while toggling the operands: result_o and ready_o stable, no new division started.
